// File: rtl/fib_term_collector_if.sv
// Stream bundle between the Fibonacci generator, the term collector and its readout stage.
// The slave side is the collector; the master side drives terms and readout ready.
interface fib_term_collector_if #(
   parameter int unsigned W  = 6,
   parameter int unsigned IW = 8
);
   logic          in_valid;
   logic [W-1:0]  in_term;
   logic          out_ready;
   logic          out_valid;
   logic [W-1:0]  out_term;
   logic [IW-1:0] out_index;

   modport slave (
      input  in_valid, in_term, out_ready,
      output out_valid, out_term, out_index
   );

   modport master (
      output in_valid, in_term, out_ready,
      input  out_valid, out_term, out_index
   );
endinterface

// File: rtl/fib_term_collector.sv
// Captures generator terms with their sequence index into a FWFT FIFO, counts drops when full,
// and flags the first W-bit wrap of the recurrence using the last two presented terms.
module fib_term_collector #(
   parameter int unsigned W     = 6,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   fib_term_collector_if.slave      bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic [IW-1:0]            drop_cnt,
   output logic                     ovf,
   output logic [IW-1:0]            ovf_index
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = W + IW;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [IW-1:0] seq_idx_q, drop_q, ovf_idx_q;
   logic          ovf_q;
   logic [W-1:0]  p0_q, p1_q;
   logic [1:0]    fill_q;

   logic          push, drop, pop, wrap, empty;
   logic [W:0]    sum;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CW'(DEPTH));
      push  = bus.in_valid && !full;
      drop  = bus.in_valid && full;
      pop   = !empty && bus.out_ready;
      sum   = {1'b0, p0_q} + {1'b0, p1_q};
      // Carry out of the W-bit sum of the two previous terms means this term has wrapped.
      wrap  = bus.in_valid && (fill_q == 2'd2) && sum[W] && !ovf_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         seq_idx_q <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
         ovf_idx_q <= '0;
         p0_q      <= '0;
         p1_q      <= '0;
         fill_q    <= '0;
      end else if (clear) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         seq_idx_q <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
         ovf_idx_q <= '0;
         p0_q      <= '0;
         p1_q      <= '0;
         fill_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
         if (drop && drop_q != {IW{1'b1}}) drop_q <= drop_q + IW'(1);
         if (bus.in_valid) begin
            if (seq_idx_q != {IW{1'b1}}) seq_idx_q <= seq_idx_q + IW'(1);
            p0_q <= p1_q;
            p1_q <= bus.in_term;
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         end
         if (wrap) begin
            ovf_q     <= 1'b1;
            ovf_idx_q <= seq_idx_q;
         end
      end
   end

   // Storage needs no reset: stale entries are masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (!clear && push) mem_q[wr_ptr_q] <= {bus.in_term, seq_idx_q};
   end

   always_comb begin
      bus.out_valid = !empty;
      bus.out_term  = empty ? '0 : mem_q[rd_ptr_q][EW-1:IW];
      bus.out_index = empty ? '0 : mem_q[rd_ptr_q][IW-1:0];
      count         = count_q;
      drop_cnt      = drop_q;
      ovf           = ovf_q;
      ovf_index     = ovf_idx_q;
   end
endmodule

// File: tb/tb_fib_term_collector.sv
// Directed bench for fib_term_collector: fill/drain, drops, wrap flag, clear, saturation, reset.
module tb_fib_term_collector;
   localparam int unsigned W     = 6;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned IW    = 8;

   logic          clk, rst, clear;
   logic [3:0]    count;
   logic          full, ovf;
   logic [IW-1:0] drop_cnt, ovf_index;
   int            n_tests = 0;
   int            n_fail  = 0;

   fib_term_collector_if #(.W(W), .IW(IW)) bus ();

   fib_term_collector #(.W(W), .DEPTH(DEPTH), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .bus       (bus),
      .count     (count),
      .full      (full),
      .drop_cnt  (drop_cnt),
      .ovf       (ovf),
      .ovf_index (ovf_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_term(input logic [W-1:0] t);
      bus.in_valid = 1'b1;
      bus.in_term  = t;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int fib[10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
      int t6[3]   = '{2, 3, 4};

      rst = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_term = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst count", 32'(count), 0);
      check("rst out_valid", 32'(bus.out_valid), 0);
      check("rst drop_cnt", 32'(drop_cnt), 0);
      check("rst ovf", 32'(ovf), 0);
      rst = 1'b0;
      tick();

      // 1: fill five terms without readout
      for (int i = 0; i < 5; i++) push_term(W'(fib[i]));
      check("t1 count", 32'(count), 5);
      check("t1 out_term", 32'(bus.out_term), 1);
      check("t1 out_index", 32'(bus.out_index), 0);
      check("t1 ovf", 32'(ovf), 0);

      // 2: drain in order
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t2 out_valid", 32'(bus.out_valid), 1);
         check("t2 out_term", 32'(bus.out_term), 32'(fib[i]));
         check("t2 out_index", 32'(bus.out_index), 32'(i));
         tick();
      end
      check("t2 drained", 32'(bus.out_valid), 0);
      bus.out_ready = 1'b0;

      // 3: overfill by two
      pulse_clear();
      for (int i = 0; i < 10; i++) push_term(W'(fib[i]));
      check("t3 full", 32'(full), 1);
      check("t3 count", 32'(count), 8);
      check("t3 drop_cnt", 32'(drop_cnt), 2);
      check("t3 ovf", 32'(ovf), 0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t3 out_index", 32'(bus.out_index), 32'(i));
         check("t3 out_term", 32'(bus.out_term), 32'(fib[i]));
         tick();
      end
      check("t3 drained", 32'(bus.out_valid), 0);
      bus.out_ready = 1'b0;

      // 4: wrap detection; 34+55 carries, 55+25 also carries but index is sticky
      pulse_clear();
      push_term(6'd21);
      push_term(6'd34);
      push_term(6'd55);
      check("t4 no ovf", 32'(ovf), 0);
      push_term(6'd25);
      check("t4 ovf", 32'(ovf), 1);
      check("t4 ovf_index", 32'(ovf_index), 3);
      push_term(6'd16);
      check("t4 ovf sticky", 32'(ovf), 1);
      check("t4 ovf_index sticky", 32'(ovf_index), 3);
      check("t4 count", 32'(count), 5);

      // 5: clear outranks push and pop
      bus.out_ready = 1'b1;
      tick();
      check("t5 pre count", 32'(count), 4);
      clear = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_term = 6'd7;
      tick();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("t5 count", 32'(count), 0);
      check("t5 out_valid", 32'(bus.out_valid), 0);
      check("t5 drop_cnt", 32'(drop_cnt), 0);
      check("t5 ovf", 32'(ovf), 0);
      push_term(6'd9);
      check("t5 out_index", 32'(bus.out_index), 0);
      check("t5 out_term", 32'(bus.out_term), 9);

      // Index and drop counter saturation
      pulse_clear();
      bus.out_ready = 1'b1;
      bus.in_term = '0;
      bus.in_valid = 1'b1;
      repeat (260) tick();
      bus.in_valid = 1'b0;
      tick();
      check("sat empty", 32'(count), 0);
      bus.out_ready = 1'b0;
      push_term(6'd3);
      check("sat out_index", 32'(bus.out_index), 255);
      bus.in_term = '0;
      bus.in_valid = 1'b1;
      repeat (300) tick();
      bus.in_valid = 1'b0;
      check("sat drop_cnt", 32'(drop_cnt), 255);
      check("sat full", 32'(full), 1);
      check("sat ovf", 32'(ovf), 0);

      // 6: simultaneous push and pop, then asynchronous reset
      pulse_clear();
      push_term(6'd1);
      push_term(6'd2);
      push_term(6'd3);
      bus.in_valid = 1'b1;
      bus.in_term = 6'd4;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      check("t6 count", 32'(count), 3);
      check("t6 head", 32'(bus.out_term), 2);
      check("t6 head index", 32'(bus.out_index), 1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t6 order", 32'(bus.out_term), 32'(t6[i]));
         tick();
      end
      bus.out_ready = 1'b0;
      push_term(6'd5);
      push_term(6'd6);
      check("t6 refill", 32'(count), 2);
      #2;
      rst = 1'b1;
      #1;
      check("t6 rst count", 32'(count), 0);
      check("t6 rst out_valid", 32'(bus.out_valid), 0);
      check("t6 rst out_term", 32'(bus.out_term), 0);
      check("t6 rst out_index", 32'(bus.out_index), 0);
      tick();
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
